// File: rtl/fetch_pc_unit_pkg.sv
// Shared constants for the fetch stage: exception codes, reset/handler vectors,
// legal IM window and the opcode/funct fields that identify branches and jumps.
package fetch_pc_unit_pkg;

  localparam logic [4:0]  EXC_INT  = 5'd0;
  localparam logic [4:0]  EXC_ADEL = 5'd4;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] DEF_HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] DEF_IM_LO      = 32'h0000_3000;
  localparam logic [31:0] DEF_IM_HI      = 32'h0000_6FFC;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [4:0] RT_BLTZ    = 5'h00;
  localparam logic [4:0] RT_BGEZ    = 5'h01;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;

  typedef struct packed {
    logic [31:0] pc;
    logic        bd;
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_unit_predecode.sv
// Combinational predecoder: flags any branch or jump whose successor sits in a
// delay slot. Also reused by the D-stage controller.
module fetch_predecode
  import fetch_pc_unit_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic        is_bj_o
);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    is_bj_o = 1'b0;
    casez (instr_i)
      {OP_BEQ,  26'b?}, {OP_BNE, 26'b?}, {OP_BLEZ, 26'b?},
      {OP_BGTZ, 26'b?}, {OP_J,   26'b?}, {OP_JAL,  26'b?}:    is_bj_o = 1'b1;
      {OP_REGIMM, 5'b?, RT_BLTZ, 16'b?},
      {OP_REGIMM, 5'b?, RT_BGEZ, 16'b?}:                      is_bj_o = 1'b1;
      {OP_SPECIAL, 20'b?, FN_JR}, {OP_SPECIAL, 20'b?, FN_JALR}: is_bj_o = 1'b1;
      default:                                                is_bj_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// F-stage PC owner: next-PC priority mux, delay-slot tracking, fetch address
// check (AdEL) and instruction zeroing on a faulting fetch.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] HANDLER_PC = DEF_HANDLER_PC,
  parameter logic [31:0] IM_LO      = DEF_IM_LO,
  parameter logic [31:0] IM_HI      = DEF_IM_HI
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        En_F,
  input  logic        req,
  input  logic        eret_D,
  input  logic [31:0] EPC,
  input  logic        Jump_D,
  input  logic [31:0] Target_D,
  input  logic [31:0] Instr_IM,
  output logic [31:0] Pc_F,
  output logic [31:0] Instruction_F,
  output logic [4:0]  Exception_F,
  output logic        BD_F
);

  fetch_state_t state_q, state_d;
  logic         adel;
  logic         is_bj;

  // Unsigned compares; a wrapped PC simply lands outside the window.
  assign adel = (state_q.pc[1:0] != 2'b00) || (state_q.pc < IM_LO) || (state_q.pc > IM_HI);

  assign Pc_F          = state_q.pc;
  assign BD_F          = state_q.bd;
  assign Exception_F   = adel ? EXC_ADEL : EXC_INT;
  assign Instruction_F = adel ? 32'd0 : Instr_IM;

  // Decoding the zeroed word keeps a faulting fetch from marking a delay slot.
  fetch_predecode u_predecode (
    .instr_i (Instruction_F),
    .is_bj_o (is_bj)
  );

  always_comb begin
    state_d = state_q;
    if (req) begin
      state_d.pc = HANDLER_PC;
      state_d.bd = 1'b0;
    end else if (En_F) begin
      // A stalled redirect is dropped here; D re-presents it once En_F returns.
      if (eret_D) begin
        state_d.pc = EPC;
        state_d.bd = 1'b0;
      end else if (Jump_D) begin
        state_d.pc = Target_D;
        state_d.bd = is_bj;
      end else begin
        state_d.pc = state_q.pc + 32'd4;
        state_d.bd = is_bj;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q.pc <= RESET_PC;
      state_q.bd <= 1'b0;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: directed scenarios then random traffic,
// checked against a behavioural model of the fetch PC rules.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        reset, En_F, req, eret_D, Jump_D;
  logic [31:0] EPC, Target_D, Instr_IM;
  logic [31:0] Pc_F, Instruction_F;
  logic [4:0]  Exception_F;
  logic        BD_F;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];

  // Behavioural model state
  logic [31:0] m_pc;
  logic        m_bd;

  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam logic [31:0] ADDU   = 32'h0043_0821;
  localparam logic [31:0] BEQ    = 32'h1000_0003;
  localparam logic [31:0] BNE    = 32'h1422_FFFD;
  localparam logic [31:0] BLEZ   = 32'h1840_0004;
  localparam logic [31:0] BGTZ   = 32'h1C40_0004;
  localparam logic [31:0] BLTZ   = 32'h0440_0002;
  localparam logic [31:0] BGEZ   = 32'h0441_0002;
  localparam logic [31:0] BLTZAL = 32'h0450_0002;
  localparam logic [31:0] J      = 32'h0800_0C10;
  localparam logic [31:0] JAL    = 32'h0C00_0C04;
  localparam logic [31:0] JR     = 32'h03E0_0008;
  localparam logic [31:0] JALR   = 32'h0040_F809;
  localparam logic [31:0] LW     = 32'h8C22_0004;

  always #5 clk = ~clk;

  fetch_pc_unit dut (
    .clk           (clk),
    .reset         (reset),
    .En_F          (En_F),
    .req           (req),
    .eret_D        (eret_D),
    .EPC           (EPC),
    .Jump_D        (Jump_D),
    .Target_D      (Target_D),
    .Instr_IM      (Instr_IM),
    .Pc_F          (Pc_F),
    .Instruction_F (Instruction_F),
    .Exception_F   (Exception_F),
    .BD_F          (BD_F)
  );

  // Branch/jump membership by mnemonic: beq bne blez bgtz j jal, bltz/bgez, jr/jalr.
  function automatic bit model_isbj(input logic [31:0] w);
    int op, rt, fn;
    op = int'(w[31:26]);
    rt = int'(w[20:16]);
    fn = int'(w[5:0]);
    return (op inside {2, 3, 4, 5, 6, 7}) ||
           (op == 1 && rt inside {0, 1}) ||
           (op == 0 && fn inside {8, 9});
  endfunction

  function automatic bit model_adel(input logic [31:0] a);
    return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6FFC);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One clock of stimulus: drive inputs, push the expected F outputs for this
  // cycle, then advance the model to the state after the coming edge.
  task automatic cyc(input logic rst, input logic en, input logic rq, input logic er,
                     input logic [31:0] epc, input logic jmp, input logic [31:0] tgt,
                     input logic [31:0] instr);
    exp_t  e;
    bit    fault, bj;
    @(negedge clk);
    reset = rst; En_F = en; req = rq; eret_D = er; EPC = epc;
    Jump_D = jmp; Target_D = tgt; Instr_IM = instr;
    #1;
    fault   = model_adel(m_pc);
    e.pc    = m_pc;
    e.bd    = m_bd;
    e.exc   = fault ? 5'd4 : 5'd0;
    e.instr = fault ? 32'd0 : instr;
    sb.push_back(e);
    bj = fault ? 1'b0 : model_isbj(instr);
    if (rst)      begin m_pc = 32'h3000;   m_bd = 1'b0; end
    else if (rq)  begin m_pc = 32'h4180;   m_bd = 1'b0; end
    else if (!en) begin end
    else if (er)  begin m_pc = epc;        m_bd = 1'b0; end
    else if (jmp) begin m_pc = tgt;        m_bd = bj;   end
    else          begin m_pc = m_pc + 4;   m_bd = bj;   end
  endtask

  task automatic run(input logic [31:0] instr);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, instr);
  endtask

  task automatic jump(input logic [31:0] tgt, input logic [31:0] instr);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, tgt, instr);
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 9))
      0:       return $urandom;
      1:       return 32'h0000_2FFC;
      2:       return 32'h0000_6FFC;
      3:       return 32'h3000 + {18'd0, 12'($urandom_range(0, 4095)), 2'($urandom_range(0, 3))};
      default: return 32'h3000 + {18'd0, 12'($urandom_range(0, 4095)), 2'b00};
    endcase
  endfunction

  function automatic logic [31:0] pick_instr();
    logic [31:0] tbl [14];
    tbl = '{NOP, ADDU, BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ, BLTZAL, J, JAL, JR, JALR, LW};
    if ($urandom_range(0, 7) == 0) return $urandom;
    return tbl[$urandom_range(0, 13)];
  endfunction

  // Monitor: F outputs are presented every cycle; compare them against the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("pc",    Pc_F,                 e.pc);
        check("bd",    {31'd0, BD_F},        {31'd0, e.bd});
        check("exc",   {27'd0, Exception_F}, {27'd0, e.exc});
        check("instr", Instruction_F,        e.instr);
      end
    end
  end

  initial begin
    reset = 1'b1; En_F = 1'b1; req = 1'b0; eret_D = 1'b0; Jump_D = 1'b0;
    EPC = '0; Target_D = '0; Instr_IM = NOP;
    @(posedge clk);
    m_pc = 32'h3000;
    m_bd = 1'b0;

    // Reset held a second cycle, then sequential fetch
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, NOP);
    run(NOP);                       // 3000
    run(ADDU);                      // 3004
    run(BEQ);                       // 3008: branch in F
    jump(32'h3040, NOP);            // 300C delay slot, bd=1
    jump(32'h3010, JAL);            // 3040 bd=0, jal -> next bd=1
    // Stall at 3010 with a pending redirect that must not latch
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3ABC, ADDU);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h5000, 1'b0, 32'h0, ADDU);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, ADDU);
    // req while stalled
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, ADDU);
    // eret beats jump
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'h3024, 1'b1, 32'h3050, BEQ);
    jump(32'h3002, NOP);            // 3024 -> misaligned target
    jump(32'h6FFC, BEQ);            // 3002 AdEL, beq zeroed -> bd=0
    run(NOP);                       // 6FFC
    jump(32'h2FFC, JR);             // 7000 AdEL
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, NOP);  // 2FFC AdEL, req
    run(BGEZ);                      // 4180
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, NOP);  // held bd=1
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4000, NOP); // reset mid-stall
    run(NOP);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 99) < 2),
          1'($urandom_range(0, 99) < 80),
          1'($urandom_range(0, 99) < 5),
          1'($urandom_range(0, 99) < 6),
          pick_addr(),
          1'($urandom_range(0, 99) < 25),
          pick_addr(),
          pick_instr());
    end

    @(negedge clk);
    #3;
    check("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end

endmodule
